// File: rtl/rr_select_encoder16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin select encoder.
// No logic here; types and sizes only.
// Imported by the picker and the top level.
package rr_select_encoder16_pkg;

  localparam int NREQ  = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_select_encoder16_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping 15 -> 0.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, result used only when the arbiter is idle.
module rr_pick16
  import rr_select_encoder16_pkg::*;
(
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic        any,
  output logic [3:0]  idx
);

  logic [31:0]      req_dbl;
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;

  // Rotate so that bit ptr lands at position 0; doubling the vector makes the wrap free.
  assign req_dbl = {req, req} >> ptr;
  assign rot     = req_dbl[NREQ-1:0];
  assign any     = |req;

  // Lowest set bit of the rotated vector is the offset of the winner from ptr.
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // Adding ptr back wraps naturally in 4 bits.
  assign idx = ptr + off;

endmodule

// File: rtl/rr_select_encoder16.sv
// Round-robin arbiter for 16 requesters emitting a binary grant index plus enable for a 4:16 decoder.
// Latency: grant 1 clock after req seen in IDLE; one GAP plus one IDLE cycle between grants.
// Backpressure: owner holds grant until done, request drop or hold limit; other requests wait.
module rr_select_encoder16 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  gnt_idx,
  output logic        gnt_en,
  output logic        busy,
  output logic        timeout
);
  import rr_select_encoder16_pkg::*;

  // Last counter value of a grant; unused when MAX_HOLD is 0 (unlimited).
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_en_q, gnt_en_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             expire;
  logic             grant_exit;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req  = req[gnt_idx_q];
  assign expire     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign grant_exit = done || !owner_req || expire;

  // Next-state and next-output computation; every output is taken from its flop.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (grant_exit) begin
          state_d   = ST_GAP;
          ptr_d     = gnt_idx_q + 1'b1;
          // Timeout only when expiry alone ended the grant; done and req drop take precedence.
          timeout_d = expire && !done && owner_req;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    gnt_en_d = (state_d == ST_GRANT);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; async reset clears the enable without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      gnt_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_en_q   <= gnt_en_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_en  = gnt_en_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_select_encoder16.sv
// Directed bench for rr_select_encoder16 with a behavioural 4:16 decoder on the outputs.
// Inputs change on the falling edge; outputs checked on the falling edge after each rising edge.
// Table-driven grant/done sequence plus hand-written hold-limit, collision and reset cases.
module tb_rr_select_encoder16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  gnt_idx;
  logic        gnt_en;
  logic        busy;
  logic        timeout;
  logic [15:0] dec_d;

  int n_checks;
  int n_errors;

  rr_select_encoder16 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .busy    (busy),
    .timeout (timeout)
  );

  // Downstream 4:16 decoder in cascade with the arbiter.
  assign dec_d = gnt_en ? (16'h0001 << gnt_idx) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic        en;
    logic [3:0]  idx;
    logic        busy;
    logic        tmo;
    logic [15:0] dec;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: rising edge, then move to the falling edge for checking/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [3:0] idx,
                         input logic bsy, input logic tmo);
    check({tag, ".gnt_en"}, 32'(gnt_en), 32'(en));
    check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".timeout"}, 32'(timeout), 32'(tmo));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            req       done en    idx    busy  tmo   dec
    vecs[0]  = '{16'h0021, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 16'h0001};
    vecs[1]  = '{16'h0021, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{16'h0021, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{16'h0021, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 16'h0020};
    vecs[4]  = '{16'h0021, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{16'h8001, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{16'h8001, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 16'h8000};
    vecs[7]  = '{16'h8001, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 16'h0000};
    vecs[8]  = '{16'h8001, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{16'h8001, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 16'h0001};
    vecs[10] = '{16'h8001, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000};
    vecs[11] = '{16'h8001, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000};
    vecs[12] = '{16'h8001, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 16'h8000};
    vecs[13] = '{16'h8001, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 16'h0000};
    vecs[14] = '{16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 16'h0000};

    // Reset, then idle with no requests.
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("idle%0d", i), 1'b0, 4'd0, 1'b0, 1'b0);
    end

    // Grant/done sequence: 0 then 5, then alternating 15/0 across the wrap.
    for (int i = 0; i < 16; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].idx, vecs[i].busy, vecs[i].tmo);
      check($sformatf("vec%0d.dec", i), 32'(dec_d), 32'(vecs[i].dec));
    end

    // Hold limit: single requester, no done -> 8 grant cycles then timeout pulse.
    req  = 16'h0004;
    done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out($sformatf("hold%0d", k), 1'b1, 4'd2, 1'b1, 1'b0);
    end
    tick();
    chk_out("expire", 1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    chk_out("post_expire", 1'b0, 4'd2, 1'b0, 1'b0);
    tick();
    chk_out("regrant2", 1'b1, 4'd2, 1'b1, 1'b0);

    // done coinciding with hold expiry: done wins, no timeout.
    for (int k = 0; k < 7; k++) tick();
    chk_out("last_hold", 1'b1, 4'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_out("done_vs_expire", 1'b0, 4'd2, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    chk_out("gap_idle", 1'b0, 4'd2, 1'b0, 1'b0);

    // Owner drops its request: grant ends on the next edge.
    tick();
    chk_out("grant_drop", 1'b1, 4'd2, 1'b1, 1'b0);
    req = 16'h0000;
    tick();
    chk_out("req_drop", 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    chk_out("req_drop_idle", 1'b0, 4'd2, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then a fresh grant from ptr=0.
    req = 16'h0100;
    tick();
    chk_out("pre_rst", 1'b1, 4'd8, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("post_rst", 1'b1, 4'd8, 1'b1, 1'b0);
    check("post_rst.dec", 32'(dec_d), 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
